// File: rtl/lemonpc_pkg.sv
// rtl/lemonpc_pkg.sv - shared widths, load size codes and writeback state type for LemonPC
package lemonpc_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 5;
  localparam int DEFAULT_DATA_WIDTH = 32;

  localparam logic [1:0] LD_B = 2'd0;
  localparam logic [1:0] LD_H = 2'd1;
  localparam logic [1:0] LD_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    WB,
    WAIT_LD
  } wb_state_t;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - selects the addressed byte/half of a raw load word and extends it
module load_align
  import lemonpc_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  addr_lo,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[8*addr_lo +: 8];
    // addr_lo[0] is ignored for halves: misaligned halves trap before reaching here
    half_v = addr_lo[1] ? word[31:16] : word[15:0];
    case (size)
      LD_B:    result = {{24{~is_unsigned & byte_v[7]}}, byte_v};
      LD_H:    result = {{16{~is_unsigned & half_v[15]}}, half_v};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - LemonPC writeback: register-file write port, bypass and load-use hazards
module writeback_stage
  import lemonpc_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_wen,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_is_load,
  input  logic [1:0]            in_ld_size,
  input  logic                  in_ld_unsigned,
  input  logic [1:0]            in_addr_lo,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_rd,
  output logic [DATA_WIDTH-1:0] rf_dataD,
  output logic                  fwd_valid,
  output logic [ADDR_WIDTH-1:0] fwd_rd,
  output logic [DATA_WIDTH-1:0] fwd_data,
  input  logic [ADDR_WIDTH-1:0] q_rs1,
  input  logic [ADDR_WIDTH-1:0] q_rs2,
  output logic                  haz_rs1,
  output logic                  haz_rs2
);

  wb_state_t             state;
  logic [ADDR_WIDTH-1:0] rd_q;
  logic                  wen_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [1:0]            alo_q;
  logic                  wr_q;
  logic [DATA_WIDTH-1:0] aligned;
  logic                  accept;
  logic                  pend_live;

  load_align u_load_align (
    .word        (ld_data),
    .size        (size_q),
    .is_unsigned (uns_q),
    .addr_lo     (alo_q),
    .result      (aligned)
  );

  assign in_ready = (state != WAIT_LD);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rd_q   <= '0;
      wen_q  <= 1'b0;
      data_q <= '0;
      size_q <= LD_B;
      uns_q  <= 1'b0;
      alo_q  <= 2'd0;
      wr_q   <= 1'b0;
    end else begin
      wr_q <= 1'b0;
      case (state)
        IDLE, WB: begin
          if (accept) begin
            rd_q  <= in_rd;
            wen_q <= in_wen;
            if (in_is_load) begin
              size_q <= in_ld_size;
              uns_q  <= in_ld_unsigned;
              alo_q  <= in_addr_lo;
              state  <= WAIT_LD;
            end else begin
              data_q <= in_data;
              wr_q   <= in_wen && (in_rd != '0);
              state  <= WB;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT_LD: begin
          // a load to x0 still consumes its response, it just never writes
          if (ld_valid) begin
            data_q <= aligned;
            wr_q   <= wen_q && (rd_q != '0);
            state  <= WB;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rf_wen   = wr_q;
  assign rf_rd    = rd_q;
  assign rf_dataD = data_q;

  assign fwd_valid = wr_q;
  assign fwd_rd    = rd_q;
  assign fwd_data  = data_q;

  assign pend_live = (state == WAIT_LD) && wen_q && (rd_q != '0);
  assign haz_rs1   = pend_live && (q_rs1 == rd_q);
  assign haz_rs2   = pend_live && (q_rs2 == rd_q);

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - scoreboard bench for writeback_stage and load_align
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_wen, in_is_load, in_ld_unsigned;
  logic [4:0]  in_rd;
  logic [31:0] in_data;
  logic [1:0]  in_ld_size, in_addr_lo;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        rf_wen, fwd_valid;
  logic [4:0]  rf_rd, fwd_rd, q_rs1, q_rs2;
  logic [31:0] rf_dataD, fwd_data;
  logic        haz_rs1, haz_rs2;

  logic [31:0] la_word, la_result;
  logic [1:0]  la_size, la_alo;
  logic        la_uns;

  writeback_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_wen(in_wen), .in_data(in_data), .in_is_load(in_is_load),
    .in_ld_size(in_ld_size), .in_ld_unsigned(in_ld_unsigned), .in_addr_lo(in_addr_lo),
    .ld_valid(ld_valid), .ld_data(ld_data),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_dataD(rf_dataD),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .haz_rs1(haz_rs1), .haz_rs2(haz_rs2)
  );

  load_align u_la (
    .word(la_word), .size(la_size), .is_unsigned(la_uns), .addr_lo(la_alo), .result(la_result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // value a load returns: pick the addressed unit, then sign- or zero-extend it
  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] size,
                                           input logic uns, input logic [1:0] alo);
    int unsigned nbytes, off, bits;
    logic [31:0] mask, v;
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    if (nbytes == 4) return word;
    off  = (size == 2'd0) ? alo : (alo & 2'd2);
    bits = 8 * nbytes;
    mask = (32'd1 << bits) - 1;
    v    = (word >> (8 * off)) & mask;
    if (!uns && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  typedef struct {
    int          due;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  // model of the outstanding load
  bit         pending = 0;
  logic [4:0] p_rd;
  bit         p_wen;
  logic [1:0] p_size, p_alo;
  bit         p_uns;
  bit         mon_on = 0;

  exp_t e;
  always @(negedge clk) begin
    if (mon_on && !rst) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        chk("rf_wen", rf_wen, 1);
        chk("rf_rd", rf_rd, e.rd);
        chk("rf_dataD", rf_dataD, e.data);
        chk("fwd_valid", fwd_valid, 1);
        chk("fwd_rd", fwd_rd, e.rd);
        chk("fwd_data", fwd_data, e.data);
      end else begin
        chk("no_write", rf_wen, 0);
        chk("no_fwd", fwd_valid, 0);
      end
    end
  end

  task automatic apply(input bit v, input logic [4:0] rd, input bit wen, input logic [31:0] data,
                       input bit isld, input logic [1:0] size, input bit uns, input logic [1:0] alo,
                       input bit lv, input logic [31:0] ldd, input logic [4:0] q1, input logic [4:0] q2);
    exp_t n;
    in_valid = v; in_rd = rd; in_wen = wen; in_data = data; in_is_load = isld;
    in_ld_size = size; in_ld_unsigned = uns; in_addr_lo = alo;
    ld_valid = lv; ld_data = ldd; q_rs1 = q1; q_rs2 = q2;
    #1;
    chk("in_ready", in_ready, !pending);
    chk("haz_rs1", haz_rs1, pending && p_wen && p_rd != 0 && q1 == p_rd);
    chk("haz_rs2", haz_rs2, pending && p_wen && p_rd != 0 && q2 == p_rd);
    if (v && !pending) begin
      if (isld) begin
        pending = 1; p_rd = rd; p_wen = wen; p_size = size; p_uns = uns; p_alo = alo;
      end else if (wen && rd != 0) begin
        n.due = cyc + 1; n.rd = rd; n.data = data;
        exp_q.push_back(n);
      end
    end else if (lv && pending) begin
      pending = 0;
      if (p_wen && p_rd != 0) begin
        n.due = cyc + 1; n.rd = p_rd; n.data = ref_load(ldd, p_size, p_uns, p_alo);
        exp_q.push_back(n);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic [4:0] q1);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, q1, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    in_valid = 0; in_rd = 0; in_wen = 0; in_data = 0; in_is_load = 0;
    in_ld_size = 0; in_ld_unsigned = 0; in_addr_lo = 0;
    ld_valid = 0; ld_data = 0; q_rs1 = 0; q_rs2 = 0;
    la_word = 0; la_size = 0; la_uns = 0; la_alo = 0;

    // load_align on its own
    la_word = 32'h80FF_0000; la_size = 2'd0; la_uns = 0; la_alo = 2'd3; #1;
    chk("la_sbyte", la_result, 32'hFFFF_FF80);
    la_word = 32'h8001_7FFE; la_size = 2'd1; la_uns = 1; la_alo = 2'd2; #1;
    chk("la_uhalf_hi", la_result, 32'h0000_8001);
    la_uns = 0; la_alo = 2'd0; #1;
    chk("la_shalf_lo", la_result, 32'h0000_7FFE);
    for (int i = 0; i < 300; i++) begin
      la_word = $urandom; la_size = 2'($urandom_range(0, 3));
      la_uns = 1'($urandom_range(0, 1)); la_alo = 2'($urandom_range(0, 3)); #1;
      chk("la_random", la_result, ref_load(la_word, la_size, la_uns, la_alo));
    end

    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    chk("rst_rf_wen", rf_wen, 0);
    chk("rst_rf_rd", rf_rd, 0);
    chk("rst_rf_dataD", rf_dataD, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_haz", {haz_rs1, haz_rs2}, 0);
    mon_on = 1;

    // ALU back-to-back, then x0 suppression
    apply(1, 5, 1, 32'h11, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(1, 6, 1, 32'h22, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0);
    apply(1, 0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0); idle(0);

    // signed byte load with three wait cycles and hazard queries
    apply(1, 7, 1, 0, 1, 2'd0, 0, 2'd3, 0, 0, 0, 0);
    idle(7); idle(8); idle(7);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h80FF_0000, 7, 7);
    idle(7); idle(0);

    // half loads
    apply(1, 10, 1, 0, 1, 2'd1, 1, 2'd2, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h8001_7FFE, 0, 10);
    apply(1, 11, 1, 0, 1, 2'd1, 0, 2'd0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h8001_7FFE, 11, 0);
    idle(0); idle(0);

    // reset while waiting on a load; late response must be ignored
    apply(1, 9, 1, 0, 1, 2'd2, 0, 2'd0, 0, 0, 0, 0);
    rst = 1; in_valid = 0; ld_valid = 0;
    @(posedge clk); #1;
    rst = 0; pending = 0; exp_q.delete();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1234_5678, 9, 9);
    idle(9);

    // spurious ld_valid while idle
    apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFE_F00D, 0, 0);
    idle(0); idle(0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] rd, q1;
      rd = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
      q1 = (pending && $urandom_range(0, 1) == 1) ? p_rd : 5'($urandom);
      if (pending)
        apply($urandom_range(0, 1), rd, 1, $urandom, $urandom_range(0, 1), 2'($urandom),
              $urandom_range(0, 1), 2'($urandom), $urandom_range(0, 3) == 0, $urandom,
              q1, 5'($urandom));
      else
        apply($urandom_range(0, 3) != 0, rd, $urandom_range(0, 4) != 0, $urandom,
              $urandom_range(0, 2) == 0, 2'($urandom), $urandom_range(0, 1), 2'($urandom),
              $urandom_range(0, 7) == 0, $urandom, q1, 5'($urandom));
    end
    while (pending) apply(0, 0, 0, 0, 0, 0, 0, 0, 1, $urandom, 0, 0);
    idle(0); idle(0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
